// File: rtl/jtkunio_obj_linebuf_if.sv
// Draw-side handshake between the object tile fetcher and the line buffer.
interface jtkunio_obj_linebuf_if #(
    parameter int XW = 9
);
    logic          draw_req;
    logic [XW-1:0] draw_x;
    logic [31:0]   draw_data;
    logic [1:0]    draw_pal;
    logic          draw_hflip;
    logic          draw_busy;

    modport master (
        output draw_req, draw_x, draw_data, draw_pal, draw_hflip,
        input  draw_busy
    );

    modport slave (
        input  draw_req, draw_x, draw_data, draw_pal, draw_hflip,
        output draw_busy
    );
endinterface

// File: rtl/jtkunio_obj_linebuf.sv
// Double-banked object line buffer: the fetcher draws 8-pixel rows into the
// draw bank while the scan bank is read at hdump and erased behind the read.
// Banks exchange on the falling edge of LHBL.
module jtkunio_obj_linebuf #(
    parameter int XW = 9,
    parameter int PW = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen,
    input  logic                  LHBL,
    input  logic [XW-1:0]         hdump,
    jtkunio_obj_linebuf_if.slave  drw,
    output logic [PW-1:0]         pxl
);
    localparam int unsigned DEPTH = 2**XW;

    typedef enum logic [1:0] {CLEAR, IDLE, DRAW} state_t;

    state_t        st;
    logic [PW-1:0] mem [2][DEPTH];
    logic          scan_bank;
    logic          lhbl_l;
    logic          busy;
    logic [XW-1:0] clr_addr;
    logic [2:0]    k;
    logic [XW-1:0] lx;
    logic [31:0]   ldata;
    logic [1:0]    lpal;
    logic          lhflip;

    logic          swap;
    logic          draw_bank;
    logic [XW-1:0] draw_addr;
    logic [3:0]    nib;
    logic [PW-1:0] cur;
    logic          draw_we;

    assign drw.draw_busy = busy;

    // Swap detection and the read-modify-write decision for the current draw pixel
    always_comb begin
        swap      = pxl_cen & lhbl_l & ~LHBL;
        draw_bank = ~scan_bank;
        draw_addr = lx + {{(XW-3){1'b0}}, k};
        nib       = lhflip ? ldata[{~k, 2'b00} +: 4] : ldata[{k, 2'b00} +: 4];
        cur       = mem[draw_bank][draw_addr];
        // the pixel landing in the swap cycle is dropped along with the rest
        draw_we   = (st == DRAW) && !swap && (nib != 4'd0) && (cur[3:0] == 4'd0);
    end

    // Control FSM: clear sweep, idle/accept, 8-pixel draw with abort on swap
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= CLEAR;
            busy      <= 1'b1;
            clr_addr  <= '0;
            scan_bank <= 1'b0;
            lhbl_l    <= 1'b0;
            k         <= '0;
            lx        <= '0;
            ldata     <= '0;
            lpal      <= '0;
            lhflip    <= 1'b0;
        end else begin
            if (pxl_cen) lhbl_l <= LHBL;
            if (swap) scan_bank <= ~scan_bank;
            case (st)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end
                end
                IDLE: begin
                    if (drw.draw_req) begin
                        lx     <= drw.draw_x;
                        ldata  <= drw.draw_data;
                        lpal   <= drw.draw_pal;
                        lhflip <= drw.draw_hflip;
                        k      <= '0;
                        st     <= DRAW;
                        busy   <= 1'b1;
                    end
                end
                DRAW: begin
                    if (swap || k == 3'd7) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    st   <= CLEAR;
                    busy <= 1'b1;
                end
            endcase
        end
    end

    // Bank storage: clear sweep on both banks, erase-on-read, draw writes
    always_ff @(posedge clk) begin
        if (st == CLEAR) begin
            mem[0][clr_addr] <= '0;
            mem[1][clr_addr] <= '0;
        end
        if (pxl_cen) mem[scan_bank][hdump] <= '0;
        if (draw_we) mem[draw_bank][draw_addr] <= {lpal, nib};
    end

    // Scan output, blanked during LHBL and while the banks are being cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            pxl <= '0;
        end else if (pxl_cen) begin
            pxl <= (LHBL && st != CLEAR) ? mem[scan_bank][hdump] : '0;
        end
    end
endmodule

// File: tb/tb_jtkunio_obj_linebuf.sv
// Self-checking bench for the object line buffer: directed line readouts with
// literal expectations plus a randomized phase against a behavioural model.
module tb_jtkunio_obj_linebuf;
    localparam int XW = 9;
    localparam int PW = 6;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          pxl_cen;
    logic          LHBL;
    logic [XW-1:0] hdump;
    logic [PW-1:0] pxl;

    always #5 clk = ~clk;

    jtkunio_obj_linebuf_if #(.XW(XW)) drw ();

    jtkunio_obj_linebuf #(.XW(XW), .PW(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .LHBL    (LHBL),
        .hdump   (hdump),
        .drw     (drw),
        .pxl     (pxl)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: two images of the line, which one is on screen,
    // and how many clear/draw clocks are still owed.
    int          bank [2][N];
    int          m_scan, m_pxl, clr_left, draw_left, dx, dpal;
    bit          m_lhbl, m_busy, dflip;
    logic [31:0] dd;

    int got  [N];
    int expl [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        bit swap;
        int db, k, px, nib, a;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++) bank[b][i] = 0;
            m_scan = 0; m_lhbl = 0; m_pxl = 0; m_busy = 1;
            clr_left = N; draw_left = 0;
            return;
        end
        swap = pxl_cen && m_lhbl && !LHBL;
        db   = 1 - m_scan;
        if (pxl_cen) begin
            m_pxl = (LHBL && clr_left == 0) ? bank[m_scan][hdump] : 0;
            bank[m_scan][hdump] = 0;
        end
        if (clr_left > 0) begin
            clr_left--;
            m_busy = (clr_left != 0);
        end else if (draw_left > 0) begin
            if (swap) begin
                draw_left = 0;
                m_busy = 0;
            end else begin
                k   = 8 - draw_left;
                px  = dflip ? 7 - k : k;
                nib = int'((dd >> (4 * px)) & 32'hF);
                a   = (dx + k) % N;
                if (nib != 0 && (bank[db][a] % 16) == 0) bank[db][a] = dpal * 16 + nib;
                draw_left--;
                m_busy = (draw_left != 0);
            end
        end else if (drw.draw_req) begin
            dx = int'(drw.draw_x); dd = drw.draw_data;
            dpal = int'(drw.draw_pal); dflip = drw.draw_hflip;
            draw_left = 8; m_busy = 1;
        end
        if (pxl_cen) m_lhbl = LHBL;
        if (swap) m_scan = 1 - m_scan;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pxl", int'(pxl), m_pxl);
        chk("busy", int'(drw.draw_busy), int'(m_busy));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (drw.draw_busy && n < 2000) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(drw.draw_busy), 0);
    endtask

    task automatic draw(input int x, input logic [31:0] data, input int pal, input bit flip);
        wait_idle();
        drw.draw_x = x[XW-1:0]; drw.draw_data = data;
        drw.draw_pal = pal[1:0]; drw.draw_hflip = flip;
        drw.draw_req = 1'b1;
        step();
        drw.draw_req = 1'b0;
        wait_idle();
    endtask

    task automatic swap_banks();
        pxl_cen = 1'b1; LHBL = 1'b1;
        step();
        LHBL = 1'b0;
        step();
        pxl_cen = 1'b0;
        step();
    endtask

    task automatic scan_line();
        LHBL = 1'b1;
        for (int h = 0; h < N; h++) begin
            hdump = h[XW-1:0]; pxl_cen = 1'b1;
            step();
            got[h] = int'(pxl);
            pxl_cen = 1'b0;
            step();
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) expl[i] = 0;
    endtask

    task automatic check_line(input string name);
        int bad = -1;
        for (int i = 0; i < N; i++)
            if (bad < 0 && got[i] != expl[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s x=%0h got %0h want %0h", name, bad, got[bad], expl[bad]);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; hdump = '0;
        drw.draw_req = 1'b0; drw.draw_x = '0; drw.draw_data = '0;
        drw.draw_pal = '0; drw.draw_hflip = 1'b0;

        // reset and clear sweep length
        step();
        chk("reset_pxl", int'(pxl), 0);
        chk("reset_busy", int'(drw.draw_busy), 1);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (drw.draw_busy && n < 600);
        chk("reset_busy_len", n, 512);
        swap_banks();
        scan_line();
        clear_exp();
        check_line("reset_line");

        // basic draw
        draw(12'h010, 32'h87654321, 2, 1'b0);
        swap_banks();
        scan_line();
        clear_exp();
        for (int i = 0; i < 8; i++) expl[16 + i] = 32 + i + 1;
        check_line("basic_draw");

        // hflip and transparency: pixel0 lands at x+7, pixel2 at x+5
        draw(12'h020, 32'h00000F01, 0, 1'b1);
        swap_banks();
        scan_line();
        clear_exp();
        expl[9'h025] = 8'h0F; expl[9'h027] = 8'h01;
        check_line("hflip");

        // priority and wrap
        draw(12'h1FE, 32'h11111111, 1, 1'b0);
        draw(12'h1FF, 32'h22222222, 3, 1'b0);
        swap_banks();
        scan_line();
        clear_exp();
        expl[9'h1FE] = 8'h11; expl[9'h1FF] = 8'h11;
        for (int i = 0; i < 6; i++) expl[i] = 8'h11;
        expl[6] = 8'h32;
        check_line("prio_wrap");

        // draw_req while busy is ignored; erase-on-read leaves an empty line
        wait_idle();
        drw.draw_x = 9'h100; drw.draw_data = 32'h12345678;
        drw.draw_pal = 2'd1; drw.draw_hflip = 1'b0;
        drw.draw_req = 1'b1;
        step();
        drw.draw_req = 1'b0;
        step();
        drw.draw_x = 9'h180; drw.draw_data = 32'hFFFFFFFF; drw.draw_req = 1'b1;
        step();
        drw.draw_req = 1'b0;
        wait_idle();
        swap_banks();
        scan_line();
        clear_exp();
        for (int i = 0; i < 8; i++) expl[9'h100 + i] = 16 + 8 - i;
        check_line("busy_ignore");
        swap_banks();
        scan_line();
        clear_exp();
        check_line("erased_line");

        // abort: req three clocks before the swap; only k=0,1 get written
        wait_idle();
        pxl_cen = 1'b0; LHBL = 1'b1;
        drw.draw_x = 9'h050; drw.draw_data = 32'h44444444;
        drw.draw_pal = 2'd0; drw.draw_hflip = 1'b0;
        drw.draw_req = 1'b1;
        step();
        drw.draw_req = 1'b0;
        step();
        step();
        LHBL = 1'b0; pxl_cen = 1'b1;
        step();
        chk("abort_busy", int'(drw.draw_busy), 0);
        pxl_cen = 1'b0;
        step();
        scan_line();
        clear_exp();
        expl[9'h050] = 8'h04; expl[9'h051] = 8'h04;
        check_line("abort_line");

        // randomized traffic, including occasional mid-operation reset
        for (int c = 0; c < 6000; c++) begin
            pxl_cen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) LHBL = ~LHBL;
            hdump = XW'($urandom);
            drw.draw_req = ($urandom_range(0, 5) == 0);
            drw.draw_x = XW'($urandom);
            drw.draw_data = $urandom & $urandom;
            drw.draw_pal = 2'($urandom);
            drw.draw_hflip = 1'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        rst = 1'b0; drw.draw_req = 1'b0; pxl_cen = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
